rtc_alarm: RTL and testbench
============================

# rtc_alarm

Programmable time-of-day alarm for the RTC peripheral. Consumes the BCD seconds/minutes/hours values and the per-second tick produced by the RTC counter chain. Holds alarm registers written by the bus interface and raises a level interrupt on match. Supports per-field wildcards, snooze, a ring timeout and BCD validation of writes.

## Interface
- RING_TIMEOUT, 60: ticks the alarm rings unacknowledged before it auto-disarms to ARMED and sets missed.
- HOUR_MAX, 8'h23: largest legal BCD hour.
- clk_i  in  1  system clock
- rst_i  in  1  reset; one clock, synchronous, active-high
- sec_i  in  8  current BCD seconds; valid whenever tick_i=1
- min_i  in  8  current BCD minutes; valid whenever tick_i=1
- hour_i  in  8  current BCD hours; valid whenever tick_i=1
- tick_i  in  1  one-cycle pulse, once per second, when the time inputs hold the new time
- wr_en_i  in  1  register write strobe
- wr_addr_i  in  3  0 alm_sec, 1 alm_min, 2 alm_hour, 3 ctrl, 4 snooze_len, 5 cmd
- wr_dat_i  in  8  write data
- rd_addr_i  in  3  0–4 as write map, 6 status; others read 0
- rd_dat_o  out  8  combinational read of addressed register
- irq_o  out  1  registered, high while RINGING
- missed_o  out  1  sticky; ring timed out

## Operation
- Registers: alm_sec, alm_min, alm_hour (BCD, reset 0); ctrl bit0 en, bit1 mask_sec, bit2 mask_min, bit3 mask_hour, bits 7:4 read 0 (reset 0); snooze_len (binary, reset 0).
- cmd is write-only and reads 0. Bit0 ack, bit1 snooze, bit2 clear_err, bit3 clear_missed.
- Status (addr 6): bits 1:0 state, bit2 wr_err, bit3 missed.
- BCD check on alm_sec/alm_min: units ≤9 and tens ≤5. On alm_hour: units ≤9 and value ≤HOUR_MAX. Failing writes are discarded and set sticky wr_err.
- match = AND over unmasked fields of (alarm == current). All fields masked means match on every tick.
- FSM states: DISABLED=0, ARMED=1, RINGING=2, SNOOZING=3.
  - DISABLED → ARMED when ctrl.en is written 1.
  - ARMED → RINGING on tick_i && match. Ring counter loads 0.
  - RINGING → ARMED on ack.
  - RINGING → SNOOZING on snooze with snooze_len≠0. Snooze counter loads snooze_len. Snooze with snooze_len=0 acts as ack.
  - RINGING: ring counter increments on each tick. At RING_TIMEOUT → ARMED and missed set.
  - SNOOZING: decrements on tick. On the tick where the counter is 1 → RINGING. Ack → ARMED.
  - Any state → DISABLED when en is written 0. Clears irq and counters, not missed/wr_err.
- Simultaneous events:
  - ack and a matching tick in RINGING: ack wins; next ring needs a later match.
  - Alarm-register write and tick in the same cycle: compare uses the pre-write values.
  - Writes to alarm registers in any state are accepted with no state change.
  - In ARMED, a match that re-occurs while RINGING is ignored.
- Ring counter width ⌈log2(RING_TIMEOUT+1)⌉. Snooze counter 8 bits, never wraps (loads ≥1).

## Timing
- Writes take effect at the clock edge where wr_en_i=1.
- irq_o rises one cycle after the tick_i cycle with match. It falls one cycle after the ack/snooze write or the timeout tick.
- Snooze of N: irq_o re-rises one cycle after the N-th tick following the snooze write.
- missed_o/wr_err set one cycle after the causing event.
- After rst_i every output is 0, rd_dat_o reflects zeroed registers, and state is DISABLED.
- Reset mid-ring or mid-snooze drops irq_o the next cycle and clears the counters.

## Structure
- Package rtc_pkg holds:
  - the state encoding
  - register address constants
  - ctrl/cmd/status bit positions
  - default RING_TIMEOUT.
- Sub-module rtc_bcd_check is a combinational field validator, parameterised by max tens digit or max value, and is instantiated three times.
- FSM, counters and register file live in rtc_alarm.

## Test plan
- Write alm 12:30:05, en=1, drive ticks 12:30:04, 12:30:05 → irq_o=1 one cycle after second tick, status state=2.
- Ringing, write cmd=0x01 → irq_o=0 next cycle, state=1; repeat tick 12:30:05 → rings again.
- snooze_len=3, ring, cmd=0x02 → irq_o low for 3 ticks, high one cycle after 3rd tick; snooze with len 0 → behaves as ack.
- Write alm_sec=8'h60, alm_hour=8'h24, alm_min=8'h0A → registers unchanged, wr_err=1; cmd=0x04 → wr_err=0.
- ctrl=0x0F (all masked), RING_TIMEOUT=4 → rings on first tick, missed_o=1 and state=1 after 4 further ticks, re-rings on next tick.
- Assert rst_i while SNOOZING; write en=0 while RINGING → irq_o=0 next cycle, state=0, missed retained after en=0 only.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC alarm block.
// Holds the alarm FSM state encoding, register-map addresses,
// ctrl/cmd/status bit positions, and the default parameter values.
package rtc_pkg;

  // The encoding is visible to software in status[1:0].
  typedef enum logic [1:0] {
    StDisabled = 2'd0,
    StArmed    = 2'd1,
    StRinging  = 2'd2,
    StSnoozing = 2'd3
  } rtc_state_e;

  localparam logic [2:0] AddrAlmSec    = 3'd0;
  localparam logic [2:0] AddrAlmMin    = 3'd1;
  localparam logic [2:0] AddrAlmHour   = 3'd2;
  localparam logic [2:0] AddrCtrl      = 3'd3;
  localparam logic [2:0] AddrSnoozeLen = 3'd4;
  localparam logic [2:0] AddrCmd       = 3'd5;
  localparam logic [2:0] AddrStatus    = 3'd6;

  localparam int unsigned CtrlEn       = 0;
  localparam int unsigned CtrlMaskSec  = 1;
  localparam int unsigned CtrlMaskMin  = 2;
  localparam int unsigned CtrlMaskHour = 3;

  localparam int unsigned CmdAck        = 0;
  localparam int unsigned CmdSnooze     = 1;
  localparam int unsigned CmdClrErr     = 2;
  localparam int unsigned CmdClrMissed  = 3;

  localparam int unsigned StatWrErr  = 2;
  localparam int unsigned StatMissed = 3;

  localparam int unsigned RingTimeoutDefault = 60;
  localparam logic [7:0]  HourMaxDefault     = 8'h23;

endpackage

// File: rtl/rtc_alarm_if.sv
// Register bus between the CPU-side bridge (master) and the alarm block (slave).
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_dat  : write data
//   rd_addr : read address
//   rd_dat  : combinational read data returned by the slave
interface rtc_alarm_if;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_dat;
  logic [2:0] rd_addr;
  logic [7:0] rd_dat;

  modport master (output wr_en, wr_addr, wr_dat, rd_addr, input rd_dat);
  modport slave  (input wr_en, wr_addr, wr_dat, rd_addr, output rd_dat);
endinterface

// File: rtl/rtc_bcd_check.sv
// Combinational BCD field validator.
//   value : packed BCD byte {tens, units}
//   valid : units <= 9, tens <= MaxTens and value <= MaxValue
// Seconds/minutes use MaxTens; hours use MaxValue. Once units <= 9, the raw
// byte compare is a true numeric compare.
module rtc_bcd_check #(
  parameter logic [3:0] MaxTens  = 4'd9,
  parameter logic [7:0] MaxValue = 8'h99
) (
  input  logic [7:0] value,
  output logic       valid
);
  assign valid = (value[3:0] <= 4'd9) && (value[7:4] <= MaxTens) && (value <= MaxValue);
endmodule

// File: rtl/rtc_alarm.sv
// Programmable time-of-day alarm.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   sec_i, min_i, hour_i   : current BCD time, valid when tick_i=1
//   tick_i                 : once-per-second pulse
//   bus                    : register write/read port (slave modport)
//   irq_o                  : high while the alarm is ringing
//   missed_o               : sticky, a ring timed out unacknowledged
module rtc_alarm
  import rtc_pkg::*;
#(
  parameter int unsigned RING_TIMEOUT = RingTimeoutDefault,
  parameter logic [7:0]  HOUR_MAX     = HourMaxDefault
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  sec_i,
  input  logic [7:0]  min_i,
  input  logic [7:0]  hour_i,
  input  logic        tick_i,
  rtc_alarm_if.slave  bus,
  output logic        irq_o,
  output logic        missed_o
);

  localparam int unsigned   RingW    = $clog2(RING_TIMEOUT + 1);
  localparam logic [RingW-1:0] RingLast = RingW'(RING_TIMEOUT - 1);

  logic [7:0]       alm_sec_q, alm_min_q, alm_hour_q, snooze_len_q, snz_q;
  logic [3:0]       ctrl_q;
  logic             wr_err_q, missed_q, irq_q;
  rtc_state_e       state_q;
  logic [RingW-1:0] ring_q;

  logic sec_ok, min_ok, hour_ok;
  logic ctrl_wr, cmd_wr, disable_wr, ack, snooze, match;

  rtc_bcd_check #(.MaxTens(4'd5), .MaxValue(8'h59)) u_chk_sec (
    .value (bus.wr_dat),
    .valid (sec_ok)
  );
  rtc_bcd_check #(.MaxTens(4'd5), .MaxValue(8'h59)) u_chk_min (
    .value (bus.wr_dat),
    .valid (min_ok)
  );
  rtc_bcd_check #(.MaxTens(4'd9), .MaxValue(HOUR_MAX)) u_chk_hour (
    .value (bus.wr_dat),
    .valid (hour_ok)
  );

  assign ctrl_wr    = bus.wr_en && (bus.wr_addr == AddrCtrl);
  assign cmd_wr     = bus.wr_en && (bus.wr_addr == AddrCmd);
  assign disable_wr = ctrl_wr && !bus.wr_dat[CtrlEn];
  assign ack        = cmd_wr && bus.wr_dat[CmdAck];
  assign snooze     = cmd_wr && bus.wr_dat[CmdSnooze];

  // Compares against the registered alarm, so a same-cycle write is not seen yet.
  assign match = (ctrl_q[CtrlMaskSec]  || (alm_sec_q  == sec_i)) &&
                 (ctrl_q[CtrlMaskMin]  || (alm_min_q  == min_i)) &&
                 (ctrl_q[CtrlMaskHour] || (alm_hour_q == hour_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alm_sec_q    <= '0;
      alm_min_q    <= '0;
      alm_hour_q   <= '0;
      ctrl_q       <= '0;
      snooze_len_q <= '0;
      wr_err_q     <= 1'b0;
      missed_q     <= 1'b0;
      state_q      <= StDisabled;
      ring_q       <= '0;
      snz_q        <= '0;
      irq_q        <= 1'b0;
    end else begin
      if (bus.wr_en) begin
        case (bus.wr_addr)
          AddrAlmSec: begin
            if (sec_ok) alm_sec_q <= bus.wr_dat;
            else        wr_err_q  <= 1'b1;
          end
          AddrAlmMin: begin
            if (min_ok) alm_min_q <= bus.wr_dat;
            else        wr_err_q  <= 1'b1;
          end
          AddrAlmHour: begin
            if (hour_ok) alm_hour_q <= bus.wr_dat;
            else         wr_err_q   <= 1'b1;
          end
          AddrCtrl:      ctrl_q       <= bus.wr_dat[3:0];
          AddrSnoozeLen: snooze_len_q <= bus.wr_dat;
          AddrCmd: begin
            if (bus.wr_dat[CmdClrErr])    wr_err_q <= 1'b0;
            if (bus.wr_dat[CmdClrMissed]) missed_q <= 1'b0;
          end
          default: ;
        endcase
      end

      if (disable_wr) begin
        state_q <= StDisabled;
        irq_q   <= 1'b0;
        ring_q  <= '0;
        snz_q   <= '0;
      end else begin
        case (state_q)
          StDisabled: begin
            if (ctrl_wr) state_q <= StArmed;
          end
          StArmed: begin
            if (tick_i && match) begin
              state_q <= StRinging;
              ring_q  <= '0;
              irq_q   <= 1'b1;
            end
          end
          StRinging: begin
            // A zero-length snooze is treated as an acknowledge.
            if (ack || (snooze && (snooze_len_q == 8'd0))) begin
              state_q <= StArmed;
              irq_q   <= 1'b0;
              ring_q  <= '0;
            end else if (snooze) begin
              state_q <= StSnoozing;
              irq_q   <= 1'b0;
              ring_q  <= '0;
              snz_q   <= snooze_len_q;
            end else if (tick_i) begin
              if (ring_q == RingLast) begin
                state_q  <= StArmed;
                irq_q    <= 1'b0;
                ring_q   <= '0;
                missed_q <= 1'b1;
              end else begin
                ring_q <= ring_q + 1'b1;
              end
            end
          end
          StSnoozing: begin
            if (ack) begin
              state_q <= StArmed;
              snz_q   <= '0;
            end else if (tick_i) begin
              if (snz_q == 8'd1) begin
                state_q <= StRinging;
                ring_q  <= '0;
                irq_q   <= 1'b1;
                snz_q   <= '0;
              end else begin
                snz_q <= snz_q - 8'd1;
              end
            end
          end
          default: state_q <= StDisabled;
        endcase
      end
    end
  end

  always_comb begin
    bus.rd_dat = '0;
    unique case (bus.rd_addr)
      AddrAlmSec:    bus.rd_dat = alm_sec_q;
      AddrAlmMin:    bus.rd_dat = alm_min_q;
      AddrAlmHour:   bus.rd_dat = alm_hour_q;
      AddrCtrl:      bus.rd_dat = {4'b0, ctrl_q};
      AddrSnoozeLen: bus.rd_dat = snooze_len_q;
      AddrStatus: begin
        bus.rd_dat[1:0]        = state_q;
        bus.rd_dat[StatWrErr]  = wr_err_q;
        bus.rd_dat[StatMissed] = missed_q;
      end
      default:       bus.rd_dat = '0;
    endcase
  end

  assign irq_o    = irq_q;
  assign missed_o = missed_q;

endmodule

// File: tb/tb_rtc_alarm.sv
// Self-checking bench for rtc_alarm. Each scenario builds a list of steps
// (bus write and/or tick and/or reset for one cycle); checked steps push their
// expected irq/missed/read-data onto a scoreboard when driven, and the scenario
// pops and compares once the DUT has clocked the step.
module tb_rtc_alarm;

  typedef struct {
    logic        rst;
    logic        we;
    logic [2:0]  addr;
    logic [7:0]  dat;
    logic        tk;
    logic [23:0] hms;
    logic [2:0]  rsel;
    string       name;
    logic        irq;
    logic        missed;
    logic [7:0]  rd;
  } step_t;

  typedef struct {
    string      name;
    logic       irq;
    logic       missed;
    logic [7:0] rd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] sec_i, min_i, hour_i;
  logic       tick_i;
  logic       irq_o, missed_o;
  int         checks = 0;
  int         errors = 0;
  exp_t       exp_q[$];

  rtc_alarm_if bus ();

  rtc_alarm #(.RING_TIMEOUT(4)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .sec_i    (sec_i),
    .min_i    (min_i),
    .hour_i   (hour_i),
    .tick_i   (tick_i),
    .bus      (bus),
    .irq_o    (irq_o),
    .missed_o (missed_o)
  );

  always #5 clk = ~clk;

  function automatic step_t mk(logic r, logic we, logic [2:0] a, logic [7:0] d, logic tk,
                               logic [23:0] hms, string nm, logic ei, logic em,
                               logic [7:0] er, logic [2:0] rs);
    step_t s;
    s.rst = r; s.we = we; s.addr = a; s.dat = d; s.tk = tk; s.hms = hms; s.rsel = rs;
    s.name = nm; s.irq = ei; s.missed = em; s.rd = er;
    return s;
  endfunction

  function automatic step_t w(logic [2:0] a, logic [7:0] d, string nm, logic ei, logic em,
                              logic [7:0] er, logic [2:0] rs = 3'd6);
    return mk(1'b0, 1'b1, a, d, 1'b0, 24'h0, nm, ei, em, er, rs);
  endfunction

  function automatic step_t t(logic [23:0] hms, string nm, logic ei, logic em, logic [7:0] er);
    return mk(1'b0, 1'b0, 3'd0, 8'h0, 1'b1, hms, nm, ei, em, er, 3'd6);
  endfunction

  // Drives one step for exactly one clock cycle; returns at the following negedge.
  task automatic apply(input step_t s);
    exp_t e;
    @(negedge clk);
    bus.rd_addr = s.rsel;
    rst_i       = s.rst;
    bus.wr_en   = s.we;
    bus.wr_addr = s.addr;
    bus.wr_dat  = s.dat;
    tick_i      = s.tk;
    if (s.tk) begin
      hour_i = s.hms[23:16];
      min_i  = s.hms[15:8];
      sec_i  = s.hms[7:0];
    end
    if (s.name != "") begin
      e.name = s.name; e.irq = s.irq; e.missed = s.missed; e.rd = s.rd;
      exp_q.push_back(e);
    end
    @(negedge clk);
    rst_i     = 1'b0;
    bus.wr_en = 1'b0;
    tick_i    = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    apply(mk(1'b1, 1'b0, 3'd0, 8'h0, 1'b0, 24'h0, "", 0, 0, 8'h00, 3'd6));
    apply(mk(1'b1, 1'b0, 3'd0, 8'h0, 1'b0, 24'h0, "", 0, 0, 8'h00, 3'd6));
    for (int a = 0; a < 8; a++) begin
      bus.rd_addr = 3'(a);
      #1;
      e.name = $sformatf("reset_rd%0d", a); e.irq = 1'b0; e.missed = 1'b0; e.rd = 8'h00;
      exp_q.push_back(e);
      e = exp_q.pop_front();
      checks++;
      if ({irq_o, missed_o, bus.rd_dat} !== {e.irq, e.missed, e.rd}) begin
        errors++;
        $display("FAIL %s: got irq=%b missed=%b rd=%h want irq=%b missed=%b rd=%h",
                 e.name, irq_o, missed_o, bus.rd_dat, e.irq, e.missed, e.rd);
      end
    end
    bus.rd_addr = 3'd6;
  endtask

  task automatic run_steps_ring();
    step_t s[$];
    exp_t  e;
    s.push_back(w(3'd0, 8'h05, "", 0, 0, 8'h00));
    s.push_back(w(3'd1, 8'h30, "", 0, 0, 8'h00));
    s.push_back(w(3'd2, 8'h12, "", 0, 0, 8'h00));
    s.push_back(w(3'd3, 8'h01, "en_armed", 0, 0, 8'h01));
    s.push_back(t(24'h123004, "no_match", 0, 0, 8'h01));
    s.push_back(t(24'h123005, "ring_rise", 1, 0, 8'h02));
    s.push_back(w(3'd4, 8'h00, "rd_alm_sec", 1, 0, 8'h05, 3'd0));
    s.push_back(w(3'd4, 8'h00, "rd_alm_min", 1, 0, 8'h30, 3'd1));
    s.push_back(w(3'd4, 8'h00, "rd_alm_hour", 1, 0, 8'h12, 3'd2));
    s.push_back(w(3'd4, 8'h00, "rd_ctrl", 1, 0, 8'h01, 3'd3));
    foreach (s[i]) begin
      apply(s[i]);
      if (s[i].name != "") begin
        e = exp_q.pop_front();
        checks++;
        if ({irq_o, missed_o, bus.rd_dat} !== {e.irq, e.missed, e.rd}) begin
          errors++;
          $display("FAIL %s: got irq=%b missed=%b rd=%h want irq=%b missed=%b rd=%h",
                   e.name, irq_o, missed_o, bus.rd_dat, e.irq, e.missed, e.rd);
        end
      end
    end
  endtask

  task automatic test_ack();
    step_t s[$];
    exp_t  e;
    s.push_back(w(3'd5, 8'h01, "ack_fall", 0, 0, 8'h01));
    s.push_back(t(24'h123005, "rering", 1, 0, 8'h02));
    // Ack in the same cycle as a matching tick: ack wins.
    s.push_back(mk(1'b0, 1'b1, 3'd5, 8'h01, 1'b1, 24'h123005, "ack_beats_tick", 0, 0, 8'h01,
                   3'd6));
    s.push_back(t(24'h123005, "ring_after_ack_tick", 1, 0, 8'h02));
    foreach (s[i]) begin
      apply(s[i]);
      if (s[i].name != "") begin
        e = exp_q.pop_front();
        checks++;
        if ({irq_o, missed_o, bus.rd_dat} !== {e.irq, e.missed, e.rd}) begin
          errors++;
          $display("FAIL %s: got irq=%b missed=%b rd=%h want irq=%b missed=%b rd=%h",
                   e.name, irq_o, missed_o, bus.rd_dat, e.irq, e.missed, e.rd);
        end
      end
    end
  endtask

  task automatic test_snooze();
    step_t s[$];
    exp_t  e;
    s.push_back(w(3'd4, 8'h03, "", 0, 0, 8'h00));
    s.push_back(w(3'd5, 8'h02, "snooze_fall", 0, 0, 8'h03));
    s.push_back(t(24'h123006, "snooze_tick1", 0, 0, 8'h03));
    s.push_back(t(24'h123007, "snooze_tick2", 0, 0, 8'h03));
    s.push_back(t(24'h123008, "snooze_tick3_ring", 1, 0, 8'h02));
    s.push_back(w(3'd4, 8'h00, "", 0, 0, 8'h00));
    s.push_back(w(3'd5, 8'h02, "snooze0_is_ack", 0, 0, 8'h01));
    foreach (s[i]) begin
      apply(s[i]);
      if (s[i].name != "") begin
        e = exp_q.pop_front();
        checks++;
        if ({irq_o, missed_o, bus.rd_dat} !== {e.irq, e.missed, e.rd}) begin
          errors++;
          $display("FAIL %s: got irq=%b missed=%b rd=%h want irq=%b missed=%b rd=%h",
                   e.name, irq_o, missed_o, bus.rd_dat, e.irq, e.missed, e.rd);
        end
      end
    end
  endtask

  task automatic test_bcd_and_masks();
    step_t s[$];
    exp_t  e;
    s.push_back(w(3'd0, 8'h60, "bad_sec", 0, 0, 8'h05, 3'd0));
    s.push_back(w(3'd2, 8'h24, "bad_hour", 0, 0, 8'h12, 3'd2));
    s.push_back(w(3'd1, 8'h0A, "bad_min", 0, 0, 8'h30, 3'd1));
    s.push_back(w(3'd4, 8'h00, "wr_err_set", 0, 0, 8'h05));
    s.push_back(w(3'd5, 8'h04, "clr_err", 0, 0, 8'h01));
    s.push_back(w(3'd2, 8'h23, "hour_max_ok", 0, 0, 8'h23, 3'd2));
    s.push_back(w(3'd0, 8'h59, "sec_59_ok", 0, 0, 8'h59, 3'd0));
    s.push_back(w(3'd2, 8'h12, "", 0, 0, 8'h00));
    s.push_back(w(3'd0, 8'h05, "no_err_after_good", 0, 0, 8'h01));
    // Alarm write and tick together: compare uses the old alm_sec (05).
    s.push_back(mk(1'b0, 1'b1, 3'd0, 8'h09, 1'b1, 24'h123005, "prewrite_match", 1, 0, 8'h02,
                   3'd6));
    s.push_back(w(3'd5, 8'h01, "ack_prewrite", 0, 0, 8'h01));
    s.push_back(t(24'h123005, "postwrite_nomatch", 0, 0, 8'h01));
    s.push_back(w(3'd3, 8'h03, "mask_sec_armed", 0, 0, 8'h01));
    s.push_back(t(24'h123042, "mask_sec_ring", 1, 0, 8'h02));
    s.push_back(w(3'd5, 8'h01, "ack_mask", 0, 0, 8'h01));
    s.push_back(t(24'h123109, "min_differs", 0, 0, 8'h01));
    foreach (s[i]) begin
      apply(s[i]);
      if (s[i].name != "") begin
        e = exp_q.pop_front();
        checks++;
        if ({irq_o, missed_o, bus.rd_dat} !== {e.irq, e.missed, e.rd}) begin
          errors++;
          $display("FAIL %s: got irq=%b missed=%b rd=%h want irq=%b missed=%b rd=%h",
                   e.name, irq_o, missed_o, bus.rd_dat, e.irq, e.missed, e.rd);
        end
      end
    end
  endtask

  task automatic test_timeout();
    step_t s[$];
    exp_t  e;
    s.push_back(w(3'd3, 8'h0F, "all_mask", 0, 0, 8'h01));
    s.push_back(t(24'h000000, "all_mask_ring", 1, 0, 8'h02));
    for (int i = 0; i < 3; i++) s.push_back(t(24'h000001, "ring_hold", 1, 0, 8'h02));
    s.push_back(t(24'h000002, "timeout", 0, 1, 8'h09));
    s.push_back(t(24'h000003, "rering_after_timeout", 1, 1, 8'h0A));
    s.push_back(w(3'd5, 8'h08, "clr_missed", 1, 0, 8'h02));
    s.push_back(w(3'd5, 8'h01, "ack_after_clr", 0, 0, 8'h01));
    foreach (s[i]) begin
      apply(s[i]);
      if (s[i].name != "") begin
        e = exp_q.pop_front();
        checks++;
        if ({irq_o, missed_o, bus.rd_dat} !== {e.irq, e.missed, e.rd}) begin
          errors++;
          $display("FAIL %s: got irq=%b missed=%b rd=%h want irq=%b missed=%b rd=%h",
                   e.name, irq_o, missed_o, bus.rd_dat, e.irq, e.missed, e.rd);
        end
      end
    end
  endtask

  task automatic test_reset_and_disable();
    step_t s[$];
    exp_t  e;
    s.push_back(t(24'h000004, "ring_pre_rst", 1, 0, 8'h02));
    s.push_back(w(3'd4, 8'h02, "", 0, 0, 8'h00));
    s.push_back(w(3'd5, 8'h02, "snooze2", 0, 0, 8'h03));
    s.push_back(mk(1'b1, 1'b0, 3'd0, 8'h0, 1'b0, 24'h0, "rst_in_snooze", 0, 0, 8'h00, 3'd6));
    s.push_back(w(3'd4, 8'h00, "rst_snooze_len", 0, 0, 8'h00, 3'd4));
    s.push_back(t(24'h000005, "disabled_after_rst", 0, 0, 8'h00));
    s.push_back(w(3'd3, 8'h0F, "reen", 0, 0, 8'h01));
    s.push_back(t(24'h000006, "ring_d", 1, 0, 8'h02));
    for (int i = 0; i < 3; i++) s.push_back(t(24'h000007, "ring_d_hold", 1, 0, 8'h02));
    s.push_back(t(24'h000008, "timeout_d", 0, 1, 8'h09));
    s.push_back(t(24'h000009, "rering_d", 1, 1, 8'h0A));
    s.push_back(w(3'd3, 8'h00, "en0_in_ring", 0, 1, 8'h08));
    s.push_back(t(24'h000010, "disabled_no_ring", 0, 1, 8'h08));
    s.push_back(w(3'd3, 8'h0F, "reen_no_ring", 0, 1, 8'h09));
    foreach (s[i]) begin
      apply(s[i]);
      if (s[i].name != "") begin
        e = exp_q.pop_front();
        checks++;
        if ({irq_o, missed_o, bus.rd_dat} !== {e.irq, e.missed, e.rd}) begin
          errors++;
          $display("FAIL %s: got irq=%b missed=%b rd=%h want irq=%b missed=%b rd=%h",
                   e.name, irq_o, missed_o, bus.rd_dat, e.irq, e.missed, e.rd);
        end
      end
    end
  endtask

  initial begin
    rst_i       = 1'b1;
    tick_i      = 1'b0;
    sec_i       = 8'h00;
    min_i       = 8'h00;
    hour_i      = 8'h00;
    bus.wr_en   = 1'b0;
    bus.wr_addr = 3'd0;
    bus.wr_dat  = 8'h00;
    bus.rd_addr = 3'd6;

    test_reset();
    run_steps_ring();
    test_ack();
    test_snooze();
    test_bcd_and_masks();
    test_timeout();
    test_reset_and_disable();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
